// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / jr-after-load hazard detection for the 5-stage MIPS pipeline.
// Optional hazard statistics counters are compiled in when HAZARD_STATS_EN is defined.
module id_ex_stage #(
    parameter int          CTRL_W   = 12,
    parameter logic [2:0]  JR_PCSRC = 3'b011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic [31:0]       instruction_IF_ID,
    input  logic [31:0]       PC_plus4_IF_ID,
    input  logic [31:0]       rs_data_ID,
    input  logic [31:0]       rt_data_ID,
    input  logic [31:0]       imm_ext_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic [1:0]        RegDst_ID,
    input  logic [2:0]        PCSrc,
    input  logic              MemRead_EX_MEM,
    input  logic [4:0]        EX_MEM_Rd,
    output logic [31:0]       instruction_ID_EX,
    output logic [31:0]       PC_plus4_ID_EX,
    output logic [31:0]       rs_data_ID_EX,
    output logic [31:0]       rt_data_ID_EX,
    output logic [31:0]       imm_ext_ID_EX,
    output logic [CTRL_W-1:0] ctrl_ID_EX,
    output logic [1:0]        ID_EX_RegDst,
    output logic [4:0]        RS_ID_EX,
    output logic [4:0]        RT_ID_EX,
    output logic              RegWrite_ID_EX,
    output logic              stall_IF_ID
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       bubble_count
`endif
);

    logic [4:0] dest_ex;
    logic [4:0] rs_if;
    logic [4:0] rt_if;
    logic       load_ex;
    logic       lu_hz;
    logic       jr_hz;
    logic       hazard;
    logic       bubble;

    assign rs_if   = instruction_IF_ID[25:21];
    assign rt_if   = instruction_IF_ID[20:16];
    assign load_ex = ctrl_ID_EX[1];

    always_comb begin
        dest_ex = 5'd0;
        unique case (ID_EX_RegDst)
            2'b00:   dest_ex = instruction_ID_EX[15:11];
            2'b01:   dest_ex = instruction_ID_EX[20:16];
            2'b10:   dest_ex = 5'd31;
            default: dest_ex = 5'd0;
        endcase
    end

    // A jr needs its target in ID, so a load still in EX costs two cycles and one in MEM costs one.
    assign lu_hz  = load_ex && (dest_ex != 5'd0) && ((dest_ex == rs_if) || (dest_ex == rt_if));
    assign jr_hz  = (PCSrc == JR_PCSRC) && (rs_if != 5'd0) &&
                    ((load_ex && (dest_ex == rs_if)) || (MemRead_EX_MEM && (EX_MEM_Rd == rs_if)));
    assign hazard = lu_hz || jr_hz;

    assign stall_IF_ID = hazard && !flush && !hold;
    assign bubble      = !hold && (flush || hazard);

    // ID -> EX register boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction_ID_EX <= '0;
            PC_plus4_ID_EX    <= '0;
            rs_data_ID_EX     <= '0;
            rt_data_ID_EX     <= '0;
            imm_ext_ID_EX     <= '0;
            ctrl_ID_EX        <= '0;
            ID_EX_RegDst      <= 2'b11;
        end else if (hold) begin
            instruction_ID_EX <= instruction_ID_EX;
        end else if (bubble) begin
            instruction_ID_EX <= '0;
            PC_plus4_ID_EX    <= '0;
            rs_data_ID_EX     <= '0;
            rt_data_ID_EX     <= '0;
            imm_ext_ID_EX     <= '0;
            ctrl_ID_EX        <= '0;
            ID_EX_RegDst      <= 2'b11;
        end else begin
            instruction_ID_EX <= instruction_IF_ID;
            PC_plus4_ID_EX    <= PC_plus4_IF_ID;
            rs_data_ID_EX     <= rs_data_ID;
            rt_data_ID_EX     <= rt_data_ID;
            imm_ext_ID_EX     <= imm_ext_ID;
            ctrl_ID_EX        <= ctrl_ID;
            ID_EX_RegDst      <= RegDst_ID;
        end
    end

    assign RS_ID_EX       = instruction_ID_EX[25:21];
    assign RT_ID_EX       = instruction_ID_EX[20:16];
    assign RegWrite_ID_EX = ctrl_ID_EX[0];

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (stall_IF_ID) stall_count <= stall_count + 32'd1;
            if (bubble)      bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use, jr-after-load, $0 destination, flush/hold priority, async reset.
// Counter checks are compiled in when HAZARD_STATS_EN is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, hold, flush;
    logic [31:0] instruction_IF_ID, PC_plus4_IF_ID, rs_data_ID, rt_data_ID, imm_ext_ID;
    logic [11:0] ctrl_ID;
    logic [1:0]  RegDst_ID;
    logic [2:0]  PCSrc;
    logic        MemRead_EX_MEM;
    logic [4:0]  EX_MEM_Rd;
    logic [31:0] instruction_ID_EX, PC_plus4_ID_EX, rs_data_ID_EX, rt_data_ID_EX, imm_ext_ID_EX;
    logic [11:0] ctrl_ID_EX;
    logic [1:0]  ID_EX_RegDst;
    logic [4:0]  RS_ID_EX, RT_ID_EX;
    logic        RegWrite_ID_EX, stall_IF_ID;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count, bubble_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] LW8   = 32'h8D28_0000; // lw   $8,0($9)
    localparam logic [31:0] ADD10 = 32'h010B_5020; // add  $10,$8,$11
    localparam logic [31:0] LW31  = 32'h8FBF_0004; // lw   $31,4($sp)
    localparam logic [31:0] JR31  = 32'h03E0_0008; // jr   $31
    localparam logic [31:0] ADDI8 = 32'h2008_0005; // addi $8,$0,5
    localparam logic [31:0] JR8   = 32'h0100_0008; // jr   $8
    localparam logic [31:0] LW0   = 32'h8C20_0000; // lw   $0,0($1)
    localparam logic [31:0] ADD2  = 32'h0000_1020; // add  $2,$0,$0

    id_ex_stage #(.CTRL_W(12), .JR_PCSRC(3'b011)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .instruction_IF_ID(instruction_IF_ID), .PC_plus4_IF_ID(PC_plus4_IF_ID),
        .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID), .imm_ext_ID(imm_ext_ID),
        .ctrl_ID(ctrl_ID), .RegDst_ID(RegDst_ID), .PCSrc(PCSrc),
        .MemRead_EX_MEM(MemRead_EX_MEM), .EX_MEM_Rd(EX_MEM_Rd),
        .instruction_ID_EX(instruction_ID_EX), .PC_plus4_ID_EX(PC_plus4_ID_EX),
        .rs_data_ID_EX(rs_data_ID_EX), .rt_data_ID_EX(rt_data_ID_EX),
        .imm_ext_ID_EX(imm_ext_ID_EX), .ctrl_ID_EX(ctrl_ID_EX),
        .ID_EX_RegDst(ID_EX_RegDst), .RS_ID_EX(RS_ID_EX), .RT_ID_EX(RT_ID_EX),
        .RegWrite_ID_EX(RegWrite_ID_EX), .stall_IF_ID(stall_IF_ID)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_in(input logic [31:0] ins, input logic [31:0] pc, input logic [11:0] c,
                         input logic [1:0] rd, input logic [2:0] pcs);
        instruction_IF_ID = ins;
        PC_plus4_IF_ID    = pc;
        rs_data_ID        = pc + 32'h100;
        rt_data_ID        = pc + 32'h200;
        imm_ext_ID        = {16'h0, ins[15:0]};
        ctrl_ID           = c;
        RegDst_ID         = rd;
        PCSrc             = pcs;
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        MemRead_EX_MEM = 1'b0; EX_MEM_Rd = 5'd0;
        instruction_IF_ID = '0; PC_plus4_IF_ID = '0; rs_data_ID = '0; rt_data_ID = '0;
        imm_ext_ID = '0; ctrl_ID = '0; RegDst_ID = 2'b11; PCSrc = 3'b000;
        tick();
        check("rst_instr", instruction_ID_EX, 32'h0);
        check("rst_ctrl", {20'h0, ctrl_ID_EX}, 32'h0);
        check("rst_regdst", {30'h0, ID_EX_RegDst}, 32'h3);
        check("rst_pc", PC_plus4_ID_EX, 32'h0);
        check("rst_stall", {31'h0, stall_IF_ID}, 32'h0);
        reset = 1'b0;

        // load-use: lw $8 then add using $8
        id_in(LW8, 32'h0000_0004, 12'h003, 2'b01, 3'b000);
        tick();
        check("t1_lw_instr", instruction_ID_EX, LW8);
        check("t1_lw_regwrite", {31'h0, RegWrite_ID_EX}, 32'h1);
        id_in(ADD10, 32'h0000_0008, 12'h001, 2'b00, 3'b000);
        check("t1_stall", {31'h0, stall_IF_ID}, 32'h1);
        tick();
        check("t1_bubble_ctrl", {20'h0, ctrl_ID_EX}, 32'h0);
        check("t1_bubble_instr", instruction_ID_EX, 32'h0);
        check("t1_bubble_regdst", {30'h0, ID_EX_RegDst}, 32'h3);
        check("t1_stall_drop", {31'h0, stall_IF_ID}, 32'h0);
`ifdef HAZARD_STATS_EN
        check("t1_stall_count", stall_count, 32'd1);
        check("t1_bubble_count", bubble_count, 32'd1);
`endif
        tick();
        check("t1_add_instr", instruction_ID_EX, ADD10);
        check("t1_add_rs", {27'h0, RS_ID_EX}, 32'd8);
        check("t1_add_rt", {27'h0, RT_ID_EX}, 32'd11);
        check("t1_add_pc", PC_plus4_ID_EX, 32'h0000_0008);
        check("t1_add_rsdata", rs_data_ID_EX, 32'h0000_0108);

        // lw $31 then jr $31: two stall cycles
        id_in(LW31, 32'h0000_0010, 12'h003, 2'b01, 3'b000);
        tick();
        id_in(JR31, 32'h0000_0014, 12'h000, 2'b11, 3'b011);
        check("t2_stall_a", {31'h0, stall_IF_ID}, 32'h1);
        tick();
        MemRead_EX_MEM = 1'b1; EX_MEM_Rd = 5'd31; #1;
        check("t2_stall_b", {31'h0, stall_IF_ID}, 32'h1);
        check("t2_bubble_a", instruction_ID_EX, 32'h0);
        tick();
        MemRead_EX_MEM = 1'b0; EX_MEM_Rd = 5'd0; #1;
        check("t2_stall_c", {31'h0, stall_IF_ID}, 32'h0);
        check("t2_bubble_b", {20'h0, ctrl_ID_EX}, 32'h0);
        tick();
        check("t2_jr_instr", instruction_ID_EX, JR31);

        // nop between lw $31 and jr $31: one stall cycle
        id_in(LW31, 32'h0000_0020, 12'h003, 2'b01, 3'b000);
        tick();
        id_in(32'h0, 32'h0000_0024, 12'h000, 2'b11, 3'b000);
        check("t2n_nop_stall", {31'h0, stall_IF_ID}, 32'h0);
        tick();
        MemRead_EX_MEM = 1'b1; EX_MEM_Rd = 5'd31;
        id_in(JR31, 32'h0000_0028, 12'h000, 2'b11, 3'b011);
        check("t2n_stall_a", {31'h0, stall_IF_ID}, 32'h1);
        tick();
        MemRead_EX_MEM = 1'b0; EX_MEM_Rd = 5'd0; #1;
        check("t2n_stall_b", {31'h0, stall_IF_ID}, 32'h0);
        tick();
        check("t2n_jr_instr", instruction_ID_EX, JR31);

        // addi $8 then jr $8: forwarded, no stall
        id_in(ADDI8, 32'h0000_0030, 12'h001, 2'b01, 3'b000);
        tick();
        check("t3_regwrite", {31'h0, RegWrite_ID_EX}, 32'h1);
        check("t3_regdst", {30'h0, ID_EX_RegDst}, 32'h1);
        id_in(JR8, 32'h0000_0034, 12'h000, 2'b11, 3'b011);
        check("t3_stall", {31'h0, stall_IF_ID}, 32'h0);
        tick();
        check("t3_jr_instr", instruction_ID_EX, JR8);

        // destination $0 never stalls
        id_in(LW0, 32'h0000_0040, 12'h003, 2'b01, 3'b000);
        tick();
        id_in(ADD2, 32'h0000_0044, 12'h001, 2'b00, 3'b000);
        check("t4_stall", {31'h0, stall_IF_ID}, 32'h0);
        tick();
        check("t4_add_instr", instruction_ID_EX, ADD2);

        // flush overrides a pending load-use stall but still bubbles
        id_in(LW8, 32'h0000_0050, 12'h003, 2'b01, 3'b000);
        tick();
        id_in(ADD10, 32'h0000_0054, 12'h001, 2'b00, 3'b000);
        flush = 1'b1; #1;
        check("t5f_stall", {31'h0, stall_IF_ID}, 32'h0);
        tick();
        flush = 1'b0;
        check("t5f_bubble_instr", instruction_ID_EX, 32'h0);
        check("t5f_bubble_regdst", {30'h0, ID_EX_RegDst}, 32'h3);

        // hold freezes everything and masks the stall
        id_in(LW8, 32'h0000_0060, 12'h003, 2'b01, 3'b000);
        tick();
        id_in(ADD10, 32'h0000_0064, 12'h001, 2'b00, 3'b000);
        hold = 1'b1; #1;
        check("t5h_stall", {31'h0, stall_IF_ID}, 32'h0);
        tick();
        check("t5h_instr", instruction_ID_EX, LW8);
        check("t5h_ctrl", {20'h0, ctrl_ID_EX}, 32'h003);
        check("t5h_pc", PC_plus4_ID_EX, 32'h0000_0060);
        check("t5h_rsdata", rs_data_ID_EX, 32'h0000_0160);
        hold = 1'b0; #1;
        check("t5h_stall_after", {31'h0, stall_IF_ID}, 32'h1);
        tick();
        check("t5h_bubble", instruction_ID_EX, 32'h0);
        tick();
        check("t5h_add", instruction_ID_EX, ADD10);

        // async reset in the middle of a stall cycle
        id_in(LW8, 32'h0000_0070, 12'h003, 2'b01, 3'b000);
        tick();
        id_in(ADD10, 32'h0000_0074, 12'h001, 2'b00, 3'b000);
        check("t6_stall_before", {31'h0, stall_IF_ID}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("t6_instr", instruction_ID_EX, 32'h0);
        check("t6_ctrl", {20'h0, ctrl_ID_EX}, 32'h0);
        check("t6_regdst", {30'h0, ID_EX_RegDst}, 32'h3);
        check("t6_stall", {31'h0, stall_IF_ID}, 32'h0);
`ifdef HAZARD_STATS_EN
        check("t6_stall_count", stall_count, 32'd0);
        check("t6_bubble_count", bubble_count, 32'd0);
`endif
        #1 reset = 1'b0;
        tick();
        check("t6_add_after", instruction_ID_EX, ADD10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
